alu_flag_logger: RTL

- Downstream monitor of cs151_processor; consumes its `overflow`, `equal` and `carry` status outputs.
- Detects rising edges on each flag and timestamps every event with a free-running cycle counter.
- Buffers event records in a small FIFO, drained by a debug/trace reader over a valid/ready handshake.
- Gives verification and on-board debug a cycle-accurate history of ALU flag activity without touching the processor.

---
 rtl/alu_flag_logger.sv | 125 ++++++++++++
 1 files changed

// File: rtl/alu_flag_logger.sv
// alu_flag_logger: watches the processor's overflow/equal/carry status flags,
// records every rising edge with a free-running cycle timestamp and queues the
// records in a small FIFO that a trace reader drains over valid/ready.
// Optional build macro FLAG_LOG_FALL_EN: also log falling edges and present
// them on rd_fall (otherwise rd_fall is constant zero).
module alu_flag_logger #(
  parameter int TS_W   = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              overflow,
  input  logic              equal,
  input  logic              carry,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [2:0]        rd_rise,
  output logic [2:0]        rd_fall,
  output logic [TS_W-1:0]   rd_time,
  output logic [ADDR_W:0]   count,
  output logic [7:0]        drop_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  // Saturating increment for the drop counter: it sticks at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [2:0]        flags;
  logic [2:0]        f_q;
  logic [2:0]        rise;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [7:0]        drop_q, drop_d;
  logic              push_req;
  logic              full;
  logic              pop;
  logic              push;

  logic [2:0]        rise_mem [DEPTH];
  logic [TS_W-1:0]   time_mem [DEPTH];

  assign flags = {overflow, equal, carry};
  assign rise  = flags & ~f_q;

`ifdef FLAG_LOG_FALL_EN
  logic [2:0] fall;
  logic [2:0] fall_mem [DEPTH];
  assign fall     = ~flags & f_q;
  assign push_req = (|rise) | (|fall);
`else
  assign push_req = |rise;
`endif

  assign full     = (count_q == FULL_CNT);
  assign rd_valid = (count_q != '0);
  // rd_ready while empty is meaningless, so pop is qualified by rd_valid;
  // this also means an empty FIFO never bypasses a same-cycle push.
  assign pop      = rd_valid & rd_ready;
  // When full, a push is only accepted if a pop frees the head slot on the
  // same edge (the write lands in the slot being vacated).
  assign push     = push_req & (~full | pop);

  // Next-state for timestamp, pointers, occupancy and drop counter.
  always_comb begin
    ts_d     = ts_q + 1'b1;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)
      count_d = count_q + 1'b1;
    else if (pop && !push)
      count_d = count_q - 1'b1;
    drop_d = drop_q;
    if (push_req && !push)
      drop_d = sat_inc8(drop_q);
  end

  // Control state: cleared immediately on rst, updated every clock otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q      <= 3'b000;
      ts_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      f_q      <= flags;
      ts_q     <= ts_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Record storage: contents are don't-care until written, since the head
  // outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      rise_mem[wr_ptr_q] <= rise;
      time_mem[wr_ptr_q] <= ts_q;
`ifdef FLAG_LOG_FALL_EN
      fall_mem[wr_ptr_q] <= fall;
`endif
    end
  end

  assign rd_rise  = rd_valid ? rise_mem[rd_ptr_q] : 3'b000;
  assign rd_time  = rd_valid ? time_mem[rd_ptr_q] : '0;
`ifdef FLAG_LOG_FALL_EN
  assign rd_fall  = rd_valid ? fall_mem[rd_ptr_q] : 3'b000;
`else
  assign rd_fall  = 3'b000;
`endif
  assign count    = count_q;
  assign drop_cnt = drop_q;

endmodule
